// File: rtl/ccsds123_ctrl.sv
// Input sequencer for the CCSDS-123 predictor: tracks BIP coordinates, tags each
// sample with context flags through a one-stage slice, and drains the pipe at end of image.
module ccsds123_ctrl #(
    parameter int D          = 16,
    parameter int NX         = 4,
    parameter int NY         = 4,
    parameter int NZ         = 16,
    parameter int PIPE_DEPTH = 8,
    localparam int XW = (NX > 1) ? $clog2(NX) : 1,
    localparam int YW = (NY > 1) ? $clog2(NY) : 1,
    localparam int ZW = (NZ > 1) ? $clog2(NZ) : 1,
    localparam int DW = $clog2(PIPE_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic [D-1:0]  s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    output logic [D-1:0]  m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [ZW-1:0] m_z,
    output logic          m_first_line,
    output logic          m_first_in_line,
    output logic          m_last_in_line,
    output logic          m_first_band,
    output logic          m_last,
    output logic          busy,
    output logic          frame_done,
    output logic [1:0]    dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and a raised valid holds its data.
    typedef enum logic [1:0] {RUN, HOLD, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [ZW-1:0] z;
    logic          accept;
    logic          x_max, y_max, z_max;

    assign x_max  = (x == XW'(NX - 1));
    assign y_max  = (y == YW'(NY - 1));
    assign z_max  = (z == ZW'(NZ - 1));

    assign s_axis_tready = (state == RUN) && (!m_tvalid || m_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign busy          = (state != RUN) || m_tvalid;
    assign frame_done    = (state == DONE);
    assign dbg_state     = state;

    // BIP order: z fastest, then x, then y; everything wraps to 0 on the last sample.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            x <= '0;
            y <= '0;
            z <= '0;
        end else if (accept) begin
            if (z_max) begin
                z <= '0;
                if (x_max) begin
                    x <= '0;
                    y <= y_max ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end else begin
                z <= z + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid        <= 1'b0;
            m_tdata         <= '0;
            m_z             <= '0;
            m_first_line    <= 1'b0;
            m_first_in_line <= 1'b0;
            m_last_in_line  <= 1'b0;
            m_first_band    <= 1'b0;
            m_last          <= 1'b0;
        end else if (accept) begin
            m_tvalid        <= 1'b1;
            m_tdata         <= s_axis_tdata;
            m_z             <= z;
            m_first_line    <= (y == '0);
            m_first_in_line <= (x == '0);
            m_last_in_line  <= x_max;
            m_first_band    <= (z == '0);
            m_last          <= x_max && y_max && z_max;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Drain wait is purely time-based once the last sample has left the slice.
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        case (state)
            RUN: begin
                if (accept && x_max && y_max && z_max)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (m_tvalid && m_tready) begin
                    state_nxt = DRAIN;
                    drain_nxt = '0;
                end
            end
            DRAIN: begin
                drain_nxt = drain_cnt + 1'b1;
                if (drain_cnt == DW'(PIPE_DEPTH - 1))
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = RUN;
                drain_nxt = '0;
            end
            default: state_nxt = RUN;
        endcase
    end

endmodule
